// File: rtl/viterbi_step_ctrl_if.sv
// -----------------------------------------------------------------------------
// viterbi_step_ctrl_if
// Signal bundle between the Viterbi frame sequencer and its surroundings
// (symbol source, branch-metric units, ACS array, survivor memory, traceback).
//
// Parameters
//   ADDR_W         survivor-memory address width
//
// Signals
//   sym_valid      source -> ctrl   symbol pair valid
//   sym_pair[1:0]  source -> ctrl   received hard-decision pair
//   sym_ready      ctrl -> source   pair accepted this cycle
//   rx_pair[1:0]   ctrl -> BMUs     registered pair on the branch-metric bus
//   acs_en         ctrl -> ACS      update path metrics this cycle
//   pm_init        ctrl -> ACS      load initial path metrics
//   pm_ovf         ACS -> ctrl      some path metric MSB is set
//   norm_en        ctrl -> ACS      subtract normalisation constant this step
//   sm_wr_en       ctrl -> SMEM     survivor write strobe
//   sm_wr_addr     ctrl -> SMEM     survivor write address (step index)
//   tb_start       ctrl -> TB       one-cycle traceback launch
//   tb_start_addr  ctrl -> TB       traceback start address
//   tb_done        TB -> ctrl       traceback finished
//   busy           ctrl -> system   frame in progress
//
// Modports: master = sequencer side, slave = environment side.
// -----------------------------------------------------------------------------
interface viterbi_step_ctrl_if #(
  parameter int ADDR_W = 7
);
  logic              sym_valid;
  logic [1:0]        sym_pair;
  logic              sym_ready;
  logic [1:0]        rx_pair;
  logic              acs_en;
  logic              pm_init;
  logic              pm_ovf;
  logic              norm_en;
  logic              sm_wr_en;
  logic [ADDR_W-1:0] sm_wr_addr;
  logic              tb_start;
  logic [ADDR_W-1:0] tb_start_addr;
  logic              tb_done;
  logic              busy;

  modport master (
    input  sym_valid, sym_pair, pm_ovf, tb_done,
    output sym_ready, rx_pair, acs_en, pm_init, norm_en, sm_wr_en,
           sm_wr_addr, tb_start, tb_start_addr, busy
  );

  modport slave (
    output sym_valid, sym_pair, pm_ovf, tb_done,
    input  sym_ready, rx_pair, acs_en, pm_init, norm_en, sm_wr_en,
           sm_wr_addr, tb_start, tb_start_addr, busy
  );
endinterface

// File: rtl/viterbi_step_ctrl.sv
// -----------------------------------------------------------------------------
// viterbi_step_ctrl
// Frame-level sequencer for the 64-state Viterbi decoder core. Accepts
// received symbol pairs, registers each onto the shared branch-metric bus and
// issues one ACS step / survivor write per pair. After the last of the
// FRAME_LEN+TAIL_LEN steps it launches traceback and waits for tb_done before
// a new frame may start.
//
// Parameters
//   FRAME_LEN  information symbols per frame
//   TAIL_LEN   tail symbols per frame (K-1)
//   ADDR_W     survivor address width, 2**ADDR_W >= FRAME_LEN+TAIL_LEN
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   viterbi_step_ctrl_if.master (handshake, ACS, survivor, traceback)
// -----------------------------------------------------------------------------
module viterbi_step_ctrl #(
  parameter int FRAME_LEN = 64,
  parameter int TAIL_LEN  = 6,
  parameter int ADDR_W    = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  viterbi_step_ctrl_if.master  bus
);

  localparam int                N         = FRAME_LEN + TAIL_LEN;
  localparam logic [ADDR_W-1:0] STEP_END  = ADDR_W'(N);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    LAUNCH,
    TB_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] step_q;
  logic [ADDR_W-1:0] sm_wr_addr_q;
  logic [1:0]        rx_pair_q;
  logic              acs_en_q;
  logic              norm_en_q;
  logic              norm_pending_q;

  logic              sym_ready;
  logic              accept;
  logic              ovf_arm;

  // The step counter only advances on acceptance, and acceptance requires
  // step < N, so it stops at N without any explicit saturation logic.
  assign sym_ready = (state_q == RUN) && (step_q < STEP_END);
  assign accept    = bus.sym_valid && sym_ready;

  // An overflow flag seen while norm_en is out reflects metrics from before
  // that subtraction took effect, so it must not request a second one.
  assign ovf_arm   = (state_q == RUN) && bus.pm_ovf && !norm_en_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next state and state-decoded strobes
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves a value unassigned and infers a latch.
  always_comb begin
    state_d           = state_q;
    bus.pm_init       = 1'b0;
    bus.tb_start      = 1'b0;
    bus.tb_start_addr = '0;
    bus.busy          = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        // The pair that wakes us up is left on the bus for RUN to consume.
        if (bus.sym_valid) state_d = INIT;
      end
      INIT: begin
        bus.pm_init = 1'b1;
        state_d     = RUN;
      end
      RUN: begin
        // step reaches N on the cycle after the last acceptance; leaving one
        // cycle later lets the final acs_en complete before traceback starts.
        if (step_q == STEP_END) state_d = LAUNCH;
      end
      LAUNCH: begin
        bus.tb_start      = 1'b1;
        bus.tb_start_addr = LAST_ADDR;
        state_d           = TB_WAIT;
      end
      TB_WAIT: begin
        if (bus.tb_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Step counter, normalisation request and branch-metric bus registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q         <= '0;
      norm_pending_q <= 1'b0;
      acs_en_q       <= 1'b0;
      norm_en_q      <= 1'b0;
      sm_wr_addr_q   <= '0;
      rx_pair_q      <= 2'b00;
    end else begin
      // One ACS step per accepted pair, one cycle after acceptance.
      acs_en_q  <= accept;
      norm_en_q <= accept && (norm_pending_q || ovf_arm);

      if (accept) begin
        rx_pair_q    <= bus.sym_pair;
        sm_wr_addr_q <= step_q;
      end

      if (state_q == INIT) begin
        step_q         <= '0;
        norm_pending_q <= 1'b0;
      end else if (accept) begin
        step_q         <= step_q + ADDR_W'(1);
        // Any pending request is discharged with this step's norm_en.
        norm_pending_q <= 1'b0;
      end else if (ovf_arm) begin
        norm_pending_q <= 1'b1;
      end
    end
  end

  assign bus.sym_ready  = sym_ready;
  assign bus.rx_pair    = rx_pair_q;
  assign bus.acs_en     = acs_en_q;
  assign bus.sm_wr_en   = acs_en_q;
  assign bus.norm_en    = norm_en_q;
  assign bus.sm_wr_addr = sm_wr_addr_q;

endmodule

// File: tb/tb_viterbi_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_viterbi_step_ctrl
// Self-checking bench for viterbi_step_ctrl: a per-cycle vector table for the
// start of a frame and the normalisation corner cases, followed by whole-frame
// sequences (continuous, gapped with overflow, reset abort, back-to-back).
// -----------------------------------------------------------------------------
module tb_viterbi_step_ctrl;

  localparam int N      = 70;
  localparam int ADDR_W = 7;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  int   init_cyc;
  int   tbs_cyc;

  viterbi_step_ctrl_if #(.ADDR_W(ADDR_W)) bus();

  viterbi_step_ctrl #(
    .FRAME_LEN (64),
    .TAIL_LEN  (6),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // One vector = inputs driven this cycle + outputs expected this cycle.
  typedef struct {
    logic              v;
    logic [1:0]        p;
    logic              ovf;
    logic              done;
    logic              rdy;
    logic [1:0]        rx;
    logic              acs;
    logic              init;
    logic              norm;
    logic [ADDR_W-1:0] addr;
    logic              busy;
    logic              tbs;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Drive this cycle's inputs, then move to the middle of the next cycle.
  task automatic tick(input logic v, input logic [1:0] p, input logic o, input logic d);
    bus.sym_valid = v;
    bus.sym_pair  = p;
    bus.pm_ovf    = o;
    bus.tb_done   = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sym_ready"},     32'(bus.sym_ready),     0);
    check({tag, "_rx_pair"},       32'(bus.rx_pair),       0);
    check({tag, "_acs_en"},        32'(bus.acs_en),        0);
    check({tag, "_pm_init"},       32'(bus.pm_init),       0);
    check({tag, "_norm_en"},       32'(bus.norm_en),       0);
    check({tag, "_sm_wr_en"},      32'(bus.sm_wr_en),      0);
    check({tag, "_sm_wr_addr"},    32'(bus.sm_wr_addr),    0);
    check({tag, "_tb_start"},      32'(bus.tb_start),      0);
    check({tag, "_tb_start_addr"}, 32'(bus.tb_start_addr), 0);
    check({tag, "_busy"},          32'(bus.busy),          0);
  endtask

  // Pulse reset from the middle of a low phase, inputs idle.
  task automatic pulse_reset();
    bus.sym_valid = 1'b0;
    bus.pm_ovf    = 1'b0;
    bus.tb_done   = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one frame from IDLE. Called at a negedge with the DUT in IDLE.
  //   gaps        random sym_valid (50%) instead of continuous
  //   ovf_step    pulse pm_ovf during a forced stall once k reaches this step
  //   done_in_run hold tb_done high through RUN and LAUNCH
  //   abort_step  assert rst when this many pairs have been accepted (-1: none)
  //   tb_delay    TB_WAIT cycles before tb_done
  //   hold_valid  keep sym_valid high through LAUNCH/TB_WAIT
  task automatic run_frame(input bit gaps, input int ovf_step, input bit done_in_run,
                           input int abort_step, input int tb_delay, input bit hold_valid);
    int         k;
    int         budget;
    bit         prev_acc;
    bit         exp_norm;
    bit         nxt_norm;
    bit         pending;
    bit         arm;
    bit         ovf_done;
    logic       v;
    logic       o;
    logic [1:0] p;
    logic [1:0] last_pair;

    k = 0; budget = 0; prev_acc = 0; exp_norm = 0; pending = 0; ovf_done = 0;
    last_pair = 2'b00;

    check("idle_ready", 32'(bus.sym_ready), 0);
    check("idle_busy",  32'(bus.busy),      0);
    tick(1'b1, 2'b10, 1'b0, 1'b0);

    check("init_pm_init", 32'(bus.pm_init),   1);
    check("init_ready",   32'(bus.sym_ready), 0);
    check("init_busy",    32'(bus.busy),      1);
    init_cyc = cyc;
    tick(1'b1, 2'b01, 1'b0, 1'b0);

    while (k < N) begin
      check("run_ready",    32'(bus.sym_ready), 1);
      check("run_acs_en",   32'(bus.acs_en),    32'(prev_acc));
      check("run_sm_wr_en", 32'(bus.sm_wr_en),  32'(prev_acc));
      check("run_norm_en",  32'(bus.norm_en),   32'(exp_norm));
      check("run_pm_init",  32'(bus.pm_init),   0);
      check("run_tb_start", 32'(bus.tb_start),  0);
      check("run_busy",     32'(bus.busy),      1);
      if (prev_acc) check("run_sm_wr_addr", 32'(bus.sm_wr_addr), 32'(k - 1));
      if (k > 0)    check("run_rx_pair",    32'(bus.rx_pair),    32'(last_pair));

      if (k == abort_step) begin
        #2;
        bus.sym_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
          check("abort_no_tb_start", 32'(bus.tb_start), 0);
          check("abort_idle_busy",   32'(bus.busy),     0);
          tick(1'b0, 2'b00, 1'b0, 1'b0);
        end
        return;
      end

      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      p = 2'($urandom_range(0, 3));
      o = 1'b0;
      if (k == ovf_step && !ovf_done) begin
        v = 1'b0;
        o = 1'b1;
        ovf_done = 1;
      end

      arm      = o && !exp_norm;
      nxt_norm = v && (pending || arm);
      pending  = v ? 1'b0 : (pending || arm);

      tick(v, p, o, done_in_run);
      exp_norm = nxt_norm;
      prev_acc = v;
      if (v) begin
        last_pair = p;
        k++;
      end
      budget++;
      if (budget > 1000) begin
        check("frame_budget", 32'(k), N);
        return;
      end
    end

    // Cycle after the last acceptance: its ACS step, no more pairs taken.
    check("last_acs_en",     32'(bus.acs_en),     1);
    check("last_sm_wr_addr", 32'(bus.sm_wr_addr), N - 1);
    check("last_rx_pair",    32'(bus.rx_pair),    32'(last_pair));
    check("last_norm_en",    32'(bus.norm_en),    32'(exp_norm));
    check("last_ready",      32'(bus.sym_ready),  0);
    check("last_tb_start",   32'(bus.tb_start),   0);
    tick(1'b0, 2'b00, 1'b0, done_in_run);

    check("launch_tb_start",      32'(bus.tb_start),      1);
    check("launch_tb_start_addr", 32'(bus.tb_start_addr), N - 1);
    check("launch_acs_en",        32'(bus.acs_en),        0);
    check("launch_ready",         32'(bus.sym_ready),     0);
    check("launch_busy",          32'(bus.busy),          1);
    tbs_cyc = cyc;
    tick(hold_valid, 2'b00, 1'b0, done_in_run);

    for (int i = 0; i < tb_delay; i++) begin
      check("wait_ready",    32'(bus.sym_ready), 0);
      check("wait_busy",     32'(bus.busy),      1);
      check("wait_tb_start", 32'(bus.tb_start),  0);
      check("wait_acs_en",   32'(bus.acs_en),    0);
      check("wait_pm_init",  32'(bus.pm_init),   0);
      tick(hold_valid, 2'b00, 1'b0, 1'b0);
    end
    check("wait_final_ready",    32'(bus.sym_ready), 0);
    check("wait_final_busy",     32'(bus.busy),      1);
    check("wait_final_tb_start", 32'(bus.tb_start),  0);
    tick(hold_valid, 2'b00, 1'b0, 1'b1);

    check("done_busy",  32'(bus.busy),      0);
    check("done_ready", 32'(bus.sym_ready), 0);
  endtask

  initial begin
    int prev_tbs;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.sym_valid = 1'b0;
    bus.sym_pair  = 2'b00;
    bus.pm_ovf    = 1'b0;
    bus.tb_done   = 1'b0;

    //          v  p      ovf  done | rdy rx     acs init norm addr busy tbs
    vecs[0]  = '{0, 2'b00, 0, 1,     0, 2'b00, 0,  0,   0,   0,   0,   0}; // IDLE, tb_done ignored
    vecs[1]  = '{1, 2'b01, 0, 0,     0, 2'b00, 0,  0,   0,   0,   0,   0}; // IDLE, wake up
    vecs[2]  = '{1, 2'b10, 0, 0,     0, 2'b00, 0,  1,   0,   0,   1,   0}; // INIT, pair not taken
    vecs[3]  = '{1, 2'b11, 0, 0,     1, 2'b00, 0,  0,   0,   0,   1,   0}; // accept step 0
    vecs[4]  = '{1, 2'b10, 0, 0,     1, 2'b11, 1,  0,   0,   0,   1,   0}; // accept step 1
    vecs[5]  = '{0, 2'b00, 1, 0,     1, 2'b10, 1,  0,   0,   1,   1,   0}; // stall, overflow
    vecs[6]  = '{0, 2'b00, 0, 0,     1, 2'b10, 0,  0,   0,   1,   1,   0}; // stall, pending held
    vecs[7]  = '{1, 2'b01, 0, 0,     1, 2'b10, 0,  0,   0,   1,   1,   0}; // accept step 2
    vecs[8]  = '{1, 2'b00, 1, 0,     1, 2'b01, 1,  0,   1,   2,   1,   0}; // norm_en; ovf ignored
    vecs[9]  = '{0, 2'b00, 0, 1,     1, 2'b00, 1,  0,   0,   3,   1,   0}; // tb_done in RUN ignored
    vecs[10] = '{1, 2'b11, 0, 0,     1, 2'b00, 0,  0,   0,   3,   1,   0}; // accept step 4
    vecs[11] = '{1, 2'b01, 0, 0,     1, 2'b11, 1,  0,   0,   4,   1,   0}; // accept step 5
    vecs[12] = '{0, 2'b00, 0, 0,     1, 2'b01, 1,  0,   0,   5,   1,   0}; // no re-arm
    vecs[13] = '{0, 2'b00, 0, 0,     1, 2'b01, 0,  0,   0,   5,   1,   0}; // rx_pair holds

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      check($sformatf("vec%0d_ready", i),   32'(bus.sym_ready),  32'(vecs[i].rdy));
      check($sformatf("vec%0d_rx_pair", i), 32'(bus.rx_pair),    32'(vecs[i].rx));
      check($sformatf("vec%0d_acs_en", i),  32'(bus.acs_en),     32'(vecs[i].acs));
      check($sformatf("vec%0d_sm_wr", i),   32'(bus.sm_wr_en),   32'(vecs[i].acs));
      check($sformatf("vec%0d_pm_init", i), 32'(bus.pm_init),    32'(vecs[i].init));
      check($sformatf("vec%0d_norm_en", i), 32'(bus.norm_en),    32'(vecs[i].norm));
      check($sformatf("vec%0d_addr", i),    32'(bus.sm_wr_addr), 32'(vecs[i].addr));
      check($sformatf("vec%0d_busy", i),    32'(bus.busy),       32'(vecs[i].busy));
      check($sformatf("vec%0d_tb_start", i), 32'(bus.tb_start),  32'(vecs[i].tbs));
      tick(vecs[i].v, vecs[i].p, vecs[i].ovf, vecs[i].done);
    end

    pulse_reset();

    // Continuous frame.
    run_frame(1'b0, -1, 1'b0, -1, 3, 1'b0);
    // Random gaps, overflow in a stall at step 10, tb_done held during RUN.
    run_frame(1'b1, 10, 1'b1, -1, 20, 1'b0);
    // Reset at step 35, then a clean frame.
    run_frame(1'b0, -1, 1'b0, 35, 0, 1'b0);
    run_frame(1'b0, -1, 1'b0, -1, 2, 1'b0);
    // Back-to-back frames with immediate tb_done and sym_valid held.
    run_frame(1'b0, -1, 1'b0, -1, 0, 1'b1);
    prev_tbs = tbs_cyc;
    run_frame(1'b0, -1, 1'b0, -1, 0, 1'b0);
    check("b2b_init_after_tb_start", 32'((init_cyc - prev_tbs) >= 2), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
